// File: rtl/share_mask_gen_if.sv
// rtl/share_mask_gen_if.sv - operand-pair and share-set handshake bundle for share_mask_gen
interface share_mask_gen_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B0;
  logic [WIDTH-1:0] B1;
  logic [WIDTH-1:0] rN;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, A0, A1, B0, B1, rN
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, A0, A1, B0, B1, rN
  );
endinterface

// File: rtl/share_mask_gen.sv
// rtl/share_mask_gen.sv - splits operands a/b into Boolean shares using a Galois LFSR
// and emits fresh refresh randomness for a downstream masked half-adder.
module share_mask_gen #(
  parameter int          WIDTH        = 8,
  parameter logic [31:0] DEFAULT_SEED = 32'hACE1_2468
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           seed_load,
  input  logic [31:0]    seed,
  share_mask_gen_if.slave bus
);
  localparam int          FMAX       = 3 * WIDTH;
  localparam int          FW         = $clog2(FMAX + 1);
  localparam logic [31:0] POLY       = 32'h8020_0003;
  localparam logic [31:0] RESET_SEED = (DEFAULT_SEED == 32'h0) ? 32'h1 : DEFAULT_SEED;

  logic [31:0]      lfsr;
  logic [31:0]      lfsr_step;
  logic [31:0]      seed_guarded;
  logic [FW-1:0]    fcnt;
  logic             fresh;
  logic             in_ready;
  logic             accept;
  logic             out_valid_q;
  logic [WIDTH-1:0] ma, mb, mr;
  logic [WIDTH-1:0] a0_q, a1_q, b0_q, b1_q, rn_q;

  assign lfsr_step    = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
  assign seed_guarded = (seed == 32'h0) ? 32'h1 : seed;

  // A share set may only use LFSR bits that were all shifted in after the previous set.
  assign fresh    = (fcnt == FW'(FMAX));
  assign in_ready = fresh & ~seed_load & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  assign ma = lfsr[WIDTH-1:0];
  assign mb = lfsr[2*WIDTH-1:WIDTH];
  assign mr = lfsr[3*WIDTH-1:2*WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr        <= RESET_SEED;
      fcnt        <= '0;
      out_valid_q <= 1'b0;
      a0_q        <= '0;
      a1_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      rn_q        <= '0;
    end else begin
      if (seed_load) begin
        lfsr <= seed_guarded;
        fcnt <= '0;
      end else begin
        lfsr <= lfsr_step;
        if (accept)
          fcnt <= '0;
        else if (!fresh)
          fcnt <= fcnt + FW'(1);
      end

      // Only the masked operand is ever registered; raw a/b never reach a flop.
      if (accept) begin
        out_valid_q <= 1'b1;
        a0_q        <= bus.a ^ ma;
        a1_q        <= ma;
        b0_q        <= bus.b ^ mb;
        b1_q        <= mb;
        rn_q        <= mr;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.A0        = a0_q;
  assign bus.A1        = a1_q;
  assign bus.B0        = b0_q;
  assign bus.B1        = b1_q;
  assign bus.rN        = rn_q;
endmodule

// File: tb/tb_share_mask_gen.sv
// tb/tb_share_mask_gen.sv - randomized scoreboard bench for share_mask_gen
// against a cycle-level software model of the mask LFSR and freshness rule.
module tb_share_mask_gen;
  localparam int          W     = 8;
  localparam int          FRESH = 3 * W;
  localparam logic [31:0] DSEED = 32'hACE1_2468;

  typedef struct packed {
    logic [W-1:0] a, b, A0, A1, B0, B1, rN;
  } set_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;

  share_mask_gen_if #(.WIDTH(W)) bus ();

  share_mask_gen #(.WIDTH(W), .DEFAULT_SEED(DSEED)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed_load(seed_load),
    .seed     (seed),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  set_t        exp_q[$];
  logic [31:0] m_lfsr;
  int          m_steps;
  bit          m_ov;
  bit          known = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] guard(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  // One clock: drive inputs 2 time units after the edge, then step the model.
  task automatic cycle(input bit r, input bit sl, input logic [31:0] sd, input bit iv, input bit orr);
    bit          exp_ir;
    bit          acc;
    logic [31:0] mask_w;
    set_t        e;
    @(posedge clk);
    #2;
    rst_n         = r;
    seed_load     = sl;
    seed          = sd;
    bus.in_valid  = iv;
    bus.out_ready = orr;
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    #1;
    exp_ir = (m_steps == FRESH) && !sl && (!m_ov || orr);
    if (known) begin
      chk("out_valid", bus.out_valid, m_ov);
      chk("in_ready", bus.in_ready, exp_ir);
    end
    if (!r) begin
      m_lfsr  = guard(DSEED);
      m_steps = 0;
      m_ov    = 1'b0;
      exp_q.delete();
      known   = 1'b1;
    end else if (sl) begin
      m_lfsr  = guard(sd);
      m_steps = 0;
      m_ov    = m_ov && !orr;
    end else begin
      acc = iv && exp_ir;
      if (acc) begin
        mask_w = m_lfsr;
        e.a  = bus.a;
        e.b  = bus.b;
        e.A1 = W'(mask_w % (1 << W));
        e.B1 = W'((mask_w / (1 << W)) % (1 << W));
        e.rN = W'((mask_w / (1 << (2 * W))) % (1 << W));
        e.A0 = bus.a ^ e.A1;
        e.B0 = bus.b ^ e.B1;
        exp_q.push_back(e);
      end
      m_lfsr  = lfsr_next(m_lfsr);
      m_steps = acc ? 0 : ((m_steps < FRESH) ? m_steps + 1 : FRESH);
      m_ov    = acc ? 1'b1 : (m_ov && !orr);
    end
  endtask

  // Monitor: one sample just after every edge, while the inputs in effect at that edge are still applied.
  initial begin
    bit   prev_ov = 1'b0;
    bit   started = 1'b0;
    bit   consumed;
    set_t hold = '0;
    set_t got;
    set_t e;
    forever begin
      @(posedge clk);
      #1;
      got = {8'h0, 8'h0, bus.A0, bus.A1, bus.B0, bus.B1, bus.rN};
      if (!rst_n) begin
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_shares", got, '0);
        prev_ov = 1'b0;
        hold    = '0;
        started = 1'b1;
      end else if (started) begin
        consumed = prev_ov && bus.out_ready;
        if (bus.out_valid && (!prev_ov || consumed)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_set", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("A0", bus.A0, e.A0);
            chk("A1", bus.A1, e.A1);
            chk("B0", bus.B0, e.B0);
            chk("B1", bus.B1, e.B1);
            chk("rN", bus.rN, e.rN);
            chk("A0^A1", bus.A0 ^ bus.A1, e.a);
            chk("B0^B1", bus.B0 ^ bus.B1, e.b);
          end
          hold = got;
        end else begin
          chk("held_shares", got, hold);
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  initial begin
    int first;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    m_lfsr        = '0;
    m_steps       = 0;
    m_ov          = 1'b0;

    // Reset, then measure how long the first accept takes.
    repeat (3) cycle(0, 0, 32'h0, 1, 1);
    first = -1;
    for (int n = 1; n <= 60 && first < 0; n++) begin
      cycle(1, 0, 32'h0, 1, 1);
      if (bus.in_ready === 1'b1) first = n - 1;
    end
    chk("first_ready_delay", first, 24);
    cycle(1, 0, 32'h0, 1, 1);
    chk("out_valid_rise", bus.out_valid, 1'b1);
    repeat (200) cycle(1, 0, 32'h0, 1, 1);

    // Random traffic with occasional reseeds (some to zero).
    for (int i = 0; i < 2000; i++) begin
      cycle(1, ($urandom_range(99) == 0), ($urandom_range(3) == 0) ? 32'h0 : $urandom,
            ($urandom_range(3) != 0), ($urandom_range(9) < 6));
    end

    // Zero reseed with in_valid held: no accept that cycle, model restarts at 1.
    repeat (30) cycle(1, 0, 32'h0, 0, 1);
    cycle(1, 1, 32'h0, 1, 1);
    chk("seed_load_blocks_ready", bus.in_ready, 1'b0);
    repeat (60) cycle(1, 0, 32'h0, 1, 1);

    // Long stall, then consume and accept in one cycle.
    for (int n = 0; n < 60 && bus.out_valid !== 1'b1; n++) cycle(1, 0, 32'h0, 1, 0);
    chk("stall_out_valid", bus.out_valid, 1'b1);
    repeat (100) cycle(1, 0, 32'h0, 1, 0);
    cycle(1, 0, 32'h0, 1, 1);
    chk("consume_accept_ready", bus.in_ready, 1'b1);
    cycle(1, 0, 32'h0, 0, 0);
    chk("consume_accept_valid", bus.out_valid, 1'b1);

    // Reset while a set is pending and a new operand is offered.
    for (int n = 0; n < 60 && !(bus.out_valid === 1'b1 && m_steps == FRESH); n++) cycle(1, 0, 32'h0, 1, 0);
    cycle(0, 0, 32'h0, 1, 0);
    cycle(1, 0, 32'h0, 1, 1);
    chk("post_reset_valid", bus.out_valid, 1'b0);
    chk("post_reset_A0", bus.A0, '0);
    chk("post_reset_rN", bus.rN, '0);
    repeat (80) cycle(1, 0, 32'h0, 1, 1);

    repeat (5) cycle(1, 0, 32'h0, 0, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/share_mask_gen.md
SHARE_MASK_GEN -- requirements
Module: share_mask_gen

Interface
REQ-001 Parameter WIDTH, default 8: data width of each share and of the refresh word; legal range 1..10.
REQ-002 Parameter DEFAULT_SEED, default 32'hACE1_2468: LFSR value loaded at reset.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 seed_load  input  1  load seed into the LFSR this cycle.
REQ-006 seed  input  32  reseed value, sampled when seed_load=1.
REQ-007 in_valid  input  1  unmasked operand pair a/b presented.
REQ-008 in_ready  output  1  block accepts a/b this cycle.
REQ-009 a  input  WIDTH  unmasked operand A.
REQ-010 b  input  WIDTH  unmasked operand B.
REQ-011 out_valid  output  1  share set A0/A1/B0/B1/rN valid.
REQ-012 out_ready  input  1  downstream masked half-adder stage consumes the share set.
REQ-013 A0, A1  output  WIDTH each  Boolean shares of a.
REQ-014 B0, B1  output  WIDTH each  Boolean shares of b.
REQ-015 rN  output  WIDTH  fresh refresh randomness for the masked carry AND.

Function
REQ-016 LFSR: 32-bit Galois, right-shift; each step: lsb=lfsr[0]; lfsr=lfsr>>1; if lsb, lfsr^=32'h8020_0003; exactly one step every cycle not in reset and without seed_load.
REQ-017 All-zero guard: a seed of 32'h0 loads as 32'h0000_0001; the LFSR never holds zero.
REQ-018 Fresh counter fcnt: counts LFSR steps since the last consumption, saturates at 3*WIDTH; fresh = (fcnt == 3*WIDTH).
REQ-019 in_ready = fresh & ~seed_load & (~out_valid | out_ready), combinational from registered state and those inputs.
REQ-020 Accept = in_valid & in_ready; on accept, with L = LFSR value in that cycle: ma = L[WIDTH-1:0], mb = L[2*WIDTH-1:WIDTH], mr = L[3*WIDTH-1:2*WIDTH].
REQ-021 On accept, registered at the next edge: A0 = a^ma, A1 = ma, B0 = b^mb, B1 = mb, rN = mr, out_valid = 1.
REQ-022 On accept, fcnt is 0 after the edge, so no LFSR bit feeds two transactions; the LFSR still steps.
REQ-023 Latency: out_valid rises one cycle after accept; maximum throughput is one transaction per 3*WIDTH+1 cycles.
REQ-024 Output buffer is a single entry; while out_valid=1 and out_ready=0, A0/A1/B0/B1/rN and out_valid hold stable.
REQ-025 Handshake out_valid & out_ready without a simultaneous accept clears out_valid; data outputs keep their last values.
REQ-026 Consume and accept in the same cycle: out_valid stays 1 and the new share set replaces the old.
REQ-027 seed_load=1: at the edge the LFSR loads the guarded seed and fcnt=0; no accept occurs in that cycle even if in_valid=1; the output buffer is unaffected.
REQ-028 in_valid held while in_ready=0: no state change beyond LFSR/fcnt stepping; a/b need not be held stable by the source until accept.
REQ-029 Unmasked a/b is never stored in any register; only masked values are held.

Reset
REQ-030 When rst_n=0 at a clock edge: LFSR=DEFAULT_SEED (zero-guarded), fcnt=0, out_valid=0, A0=A1=B0=B1=rN=0; in_ready=0 from the following cycle until fresh.
REQ-031 Reset takes priority over seed_load and accept; a transaction pending during reset is discarded.

Verification
REQ-032 Release reset with WIDTH=8, hold in_valid=1 -> in_ready first =1 exactly 24 cycles after release; out_valid rises the next cycle.
REQ-033 Sweep a/b, out_ready=1 -> every transaction gives A0^A1==a and B0^B1==b; A1, B1, rN match the software Galois LFSR model bit-exactly; 25-cycle spacing.
REQ-034 seed_load with seed=0 -> the LFSR model restarts from 32'h1; the next share set matches that model; in_valid in the seed_load cycle is not accepted.
REQ-035 out_ready=0 for 100 cycles after out_valid -> outputs are stable, in_ready=0, fcnt saturates at 24; out_ready=1 with in_valid=1 -> consume and accept in the same cycle, new set appears next cycle.
REQ-036 Assert rst_n=0 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, all shares 0, LFSR=DEFAULT_SEED.
REQ-037 Chi-square test over 10^5 transactions with a fixed -> A0 is uniform over 0..255 at 5% significance.
